// File: rtl/icon_sync_ctrl_if.sv
// Bot register / icon display bundle for icon_sync_ctrl.
// master drives the bot-side inputs, slave is the controller.
interface icon_sync_ctrl_if;
  logic        upd_sysregs;
  logic [7:0]  LocX_in;
  logic [7:0]  LocY_in;
  logic [7:0]  BotInfo_in;
  logic [11:0] pixel_row;
  logic [7:0]  LocX_reg;
  logic [7:0]  LocY_reg;
  logic [7:0]  BotInfo_reg;
  logic [2:0]  icon_sel;
  logic        icon_en;
  logic        upd_ack;
  logic [7:0]  ovr_cnt;

  modport master (
    output upd_sysregs, LocX_in, LocY_in,
    output BotInfo_in, pixel_row,
    input  LocX_reg, LocY_reg, BotInfo_reg,
    input  icon_sel, icon_en, upd_ack, ovr_cnt
  );

  modport slave (
    input  upd_sysregs, LocX_in, LocY_in,
    input  BotInfo_in, pixel_row,
    output LocX_reg, LocY_reg, BotInfo_reg,
    output icon_sel, icon_en, upd_ack, ovr_cnt
  );
endinterface

// File: rtl/icon_sync_ctrl.sv
// Frame-synchronous commit of Rojobot location/info to the icon path,
// with orientation select, stopped-bot blink and overwrite counter.
module icon_sync_ctrl #(
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clock,
  input  logic             reset,
  icon_sync_ctrl_if.slave  bus
);

  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [7:0]  BF_M1 = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic        vblank_d_q, vblank_d_d;
  logic [7:0]  stg_x_q, stg_x_d;
  logic [7:0]  stg_y_q, stg_y_d;
  logic [7:0]  stg_info_q, stg_info_d;
  logic [7:0]  loc_x_q, loc_x_d;
  logic [7:0]  loc_y_q, loc_y_d;
  logic [7:0]  info_q, info_d;
  logic        ack_q, ack_d;
  logic [7:0]  ovr_q, ovr_d;
  logic [7:0]  frame_q, frame_d;
  logic        ph_q, ph_d;
  logic        vblank, vb_edge;

  always_comb begin
    state_d    = state_q;
    stg_x_d    = stg_x_q;
    stg_y_d    = stg_y_q;
    stg_info_d = stg_info_q;
    loc_x_d    = loc_x_q;
    loc_y_d    = loc_y_q;
    info_d     = info_q;
    ovr_d      = ovr_q;
    frame_d    = frame_q;
    ph_d       = ph_q;
    ack_d      = 1'b0;

    vblank     = (bus.pixel_row >= VA);
    vb_edge    = vblank & ~vblank_d_q;
    vblank_d_d = vblank;

    if (bus.upd_sysregs) begin
      stg_x_d    = bus.LocX_in;
      stg_y_d    = bus.LocY_in;
      stg_info_d = bus.BotInfo_in;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.upd_sysregs) state_d = PEND;
      end
      PEND: begin
        if (bus.upd_sysregs && ovr_q != 8'hff)
          ovr_d = ovr_q + 8'd1;
        if (vb_edge) state_d = COMMIT;
      end
      COMMIT: begin
        // copy uses pre-update staging; a new update belongs to next frame
        loc_x_d = stg_x_q;
        loc_y_d = stg_y_q;
        info_d  = stg_info_q;
        ack_d   = 1'b1;
        state_d = bus.upd_sysregs ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (vb_edge) begin
      if (frame_q == BF_M1) begin
        frame_d = 8'd0;
        ph_d    = ~ph_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      vblank_d_q <= 1'b1;
      stg_x_q    <= 8'd0;
      stg_y_q    <= 8'd0;
      stg_info_q <= 8'd0;
      loc_x_q    <= 8'd0;
      loc_y_q    <= 8'd0;
      info_q     <= 8'd0;
      ack_q      <= 1'b0;
      ovr_q      <= 8'd0;
      frame_q    <= 8'd0;
      ph_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      vblank_d_q <= vblank_d_d;
      stg_x_q    <= stg_x_d;
      stg_y_q    <= stg_y_d;
      stg_info_q <= stg_info_d;
      loc_x_q    <= loc_x_d;
      loc_y_q    <= loc_y_d;
      info_q     <= info_d;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
      frame_q    <= frame_d;
      ph_q       <= ph_d;
    end
  end

  assign bus.LocX_reg    = loc_x_q;
  assign bus.LocY_reg    = loc_y_q;
  assign bus.BotInfo_reg = info_q;
  assign bus.icon_sel    = info_q[2:0];
  assign bus.icon_en     = (|info_q[7:4]) ? 1'b1 : ph_q;
  assign bus.upd_ack     = ack_q;
  assign bus.ovr_cnt     = ovr_q;

endmodule

// File: tb/tb_icon_sync_ctrl.sv
// Self-checking bench for icon_sync_ctrl: directed scenarios with
// literal expectations plus randomized traffic against a frame model.
module tb_icon_sync_ctrl;
  localparam int VA = 480;
  localparam int BF = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acks     = 0;

  icon_sync_ctrl_if ifc ();

  icon_sync_ctrl #(.V_ACTIVE(VA), .BLINK_FRAMES(BF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, int act, int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame-level model: data waiting for a blank edge, the edge that
  // carries it, and the frame count that drives the blink phase.
  bit       m_valid = 0;
  bit       m_waiting, m_commit, m_ack, m_vprev;
  bit [7:0] m_stg [3];
  bit [7:0] m_cur [3];
  int       m_ovr, m_edges;

  always @(posedge clock) begin
    bit blank, edge_now, was_commit;
    if (reset) begin
      m_valid = 1; m_waiting = 0; m_commit = 0; m_ack = 0;
      m_vprev = 1; m_ovr = 0; m_edges = 0;
      for (int k = 0; k < 3; k++) begin
        m_stg[k] = 0; m_cur[k] = 0;
      end
    end else begin
      blank    = (ifc.pixel_row >= 12'(VA));
      edge_now = blank && !m_vprev;
      m_vprev  = blank;
      m_ack    = m_commit;
      if (m_commit) m_cur = m_stg;
      was_commit = m_commit;
      m_commit   = 0;
      if (was_commit) begin
        m_waiting = ifc.upd_sysregs;
      end else if (m_waiting) begin
        if (ifc.upd_sysregs) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
        if (edge_now) begin
          m_waiting = 0;
          m_commit  = 1;
        end
      end else if (ifc.upd_sysregs) begin
        m_waiting = 1;
      end
      if (ifc.upd_sysregs) begin
        m_stg[0] = ifc.LocX_in;
        m_stg[1] = ifc.LocY_in;
        m_stg[2] = ifc.BotInfo_in;
      end
      if (edge_now) m_edges++;
    end
  end

  always @(negedge clock) begin
    int ph, en;
    if (m_valid) begin
      ph = ((m_edges / BF) % 2 == 0) ? 1 : 0;
      en = (m_cur[2][7:4] != 0) ? 1 : ph;
      chk("model LocX", ifc.LocX_reg, m_cur[0]);
      chk("model LocY", ifc.LocY_reg, m_cur[1]);
      chk("model Info", ifc.BotInfo_reg, m_cur[2]);
      chk("model icon_sel", ifc.icon_sel, m_cur[2][2:0]);
      chk("model icon_en", ifc.icon_en, en);
      chk("model upd_ack", ifc.upd_ack, m_ack);
      chk("model ovr_cnt", ifc.ovr_cnt, m_ovr);
      if (ifc.upd_ack) acks++;
    end
  end

  task automatic cyc(bit u, logic [7:0] x, logic [7:0] y,
                     logic [7:0] i, logic [11:0] r);
    ifc.upd_sysregs = u;
    ifc.LocX_in     = x;
    ifc.LocY_in     = y;
    ifc.BotInfo_in  = i;
    ifc.pixel_row   = r;
    @(negedge clock);
  endtask

  task automatic idle(int n, logic [11:0] r);
    repeat (n) cyc(0, 8'h00, 8'h00, 8'h00, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2, 12'd100);
    reset = 1'b0;
  endtask

  task automatic frame(int n);
    repeat (n) begin
      idle(3, 12'd100);
      idle(3, 12'd480);
    end
  endtask

  initial begin
    int a0, hold;
    logic [11:0] row;
    bit u;
    ifc.upd_sysregs = 0;
    ifc.LocX_in = 0;
    ifc.LocY_in = 0;
    ifc.BotInfo_in = 0;
    ifc.pixel_row = 12'd100;
    @(negedge clock);
    do_reset();
    chk("reset LocX", ifc.LocX_reg, 0);
    chk("reset icon_sel", ifc.icon_sel, 0);
    chk("reset icon_en", ifc.icon_en, 1);
    chk("reset ovr_cnt", ifc.ovr_cnt, 0);

    cyc(1, 8'h10, 8'h20, 8'h13, 12'd100);
    idle(1, 12'd100);
    chk("pre-edge LocX", ifc.LocX_reg, 0);
    idle(1, 12'd480);
    chk("edge+1 LocX", ifc.LocX_reg, 0);
    chk("edge+1 ack", ifc.upd_ack, 0);
    idle(1, 12'd480);
    chk("edge+2 LocX", ifc.LocX_reg, 8'h10);
    chk("edge+2 LocY", ifc.LocY_reg, 8'h20);
    chk("edge+2 icon_sel", ifc.icon_sel, 3);
    chk("edge+2 ack", ifc.upd_ack, 1);
    idle(1, 12'd480);
    chk("edge+3 ack", ifc.upd_ack, 0);

    do_reset();
    cyc(1, 8'd1, 8'd0, 8'd0, 12'd100);
    cyc(1, 8'd2, 8'd0, 8'd0, 12'd100);
    cyc(1, 8'd3, 8'd0, 8'd0, 12'd100);
    idle(3, 12'd480);
    chk("triple LocX", ifc.LocX_reg, 3);
    chk("triple ovr_cnt", ifc.ovr_cnt, 2);

    do_reset();
    cyc(1, 8'd4, 8'd0, 8'd0, 12'd100);
    cyc(1, 8'd5, 8'd0, 8'd0, 12'd480);
    idle(2, 12'd480);
    chk("pend+edge LocX", ifc.LocX_reg, 5);
    chk("pend+edge ovr", ifc.ovr_cnt, 1);

    do_reset();
    idle(1, 12'd100);
    cyc(1, 8'd5, 8'd0, 8'd0, 12'd480);
    idle(4, 12'd480);
    chk("idle+edge held", ifc.LocX_reg, 0);
    idle(3, 12'd100);
    idle(3, 12'd480);
    chk("idle+edge next", ifc.LocX_reg, 5);

    do_reset();
    a0 = acks;
    cyc(1, 8'd7, 8'd0, 8'd0, 12'd100);
    idle(1, 12'd480);
    cyc(1, 8'd8, 8'd0, 8'd0, 12'd480);
    chk("commit-cyc old", ifc.LocX_reg, 7);
    idle(3, 12'd480);
    idle(3, 12'd100);
    idle(3, 12'd480);
    chk("commit-cyc new", ifc.LocX_reg, 8);
    chk("commit-cyc ovr", ifc.ovr_cnt, 0);
    idle(1, 12'd480);
    chk("commit-cyc acks", acks - a0, 2);

    do_reset();
    frame(1);
    chk("blink e1", ifc.icon_en, 1);
    frame(1);
    chk("blink e2", ifc.icon_en, 0);
    frame(1);
    chk("blink e3", ifc.icon_en, 0);
    frame(1);
    chk("blink e4", ifc.icon_en, 1);
    cyc(1, 8'd0, 8'd0, 8'h40, 12'd100);
    frame(2);
    chk("moving e6", ifc.icon_en, 1);
    frame(1);
    chk("moving e7", ifc.icon_en, 1);

    do_reset();
    repeat (301) cyc(1, 8'h55, 8'h66, 8'h77, 12'd100);
    chk("ovr sat", ifc.ovr_cnt, 255);
    reset = 1'b1;
    idle(1, 12'd100);
    reset = 1'b0;
    chk("mid reset ovr", ifc.ovr_cnt, 0);
    chk("mid reset en", ifc.icon_en, 1);
    a0 = acks;
    idle(3, 12'd100);
    idle(3, 12'd480);
    idle(1, 12'd100);
    chk("mid reset LocX", ifc.LocX_reg, 0);
    chk("mid reset acks", acks - a0, 0);

    hold = 0;
    row  = 12'd100;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        row  = ($urandom % 2 == 0) ? 12'($urandom_range(0, 479))
                                   : 12'($urandom_range(480, 600));
        hold = $urandom_range(1, 6);
      end
      hold--;
      u = ($urandom % 4 == 0);
      reset = ($urandom % 500 == 0);
      cyc(u, 8'($urandom), 8'($urandom), 8'($urandom), row);
    end
    reset = 1'b0;
    idle(2, 12'd100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/icon_sync_ctrl.md
# icon_sync_ctrl

Frame-synchronous update controller between the Rojobot register interface and the icon display path. It captures bot location and info on each `upd_sysregs` pulse into staging registers. At the start of vertical blanking it commits them to the registers that drive the icon, so the icon never tears mid-frame. It also generates the icon orientation select, a stopped-bot blink enable, and an overwrite counter for updates lost between frames.

## Interface
Parameters:
- `V_ACTIVE`, 480, first non-visible pixel row; `pixel_row >= V_ACTIVE` means vertical blank
- `BLINK_FRAMES`, 30, frames per blink half-period; range 1..255

Ports:
- `clock`  in  1  system clock; every register updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `upd_sysregs`  in  1  one-cycle pulse: bot registers changed
- `LocX_in`  in  8  bot X location from the bot
- `LocY_in`  in  8  bot Y location from the bot
- `BotInfo_in`  in  8  bot info; [2:0] orientation, [7:4] movement
- `pixel_row`  in  12  current display row from the display timing generator
- `LocX_reg`  out  8  committed X location, drives the icon
- `LocY_reg`  out  8  committed Y location, drives the icon
- `BotInfo_reg`  out  8  committed bot info
- `icon_sel`  out  3  equals `BotInfo_reg[2:0]`; selects the orientation icon
- `icon_en`  out  1  icon visible; toggles while the bot is stopped
- `upd_ack`  out  1  one-cycle pulse when a commit lands
- `ovr_cnt`  out  8  saturating count of staged updates overwritten before commit

## Operation
- Blank detect: `vblank = (pixel_row >= V_ACTIVE)`. `vblank_d` is a one-clock registered copy. `vb_edge = vblank & ~vblank_d`.
- Staging registers `stg_x`, `stg_y`, `stg_info` load `LocX_in`, `LocY_in`, `BotInfo_in` on any cycle where `upd_sysregs` = 1, in every state.
- The FSM has three states: IDLE, PEND, COMMIT.
- IDLE:
  - `upd_sysregs` → PEND.
  - `vb_edge` alone → no action.
  - `upd_sysregs` and `vb_edge` in the same cycle → PEND; the commit waits for the next frame.
- PEND:
  - `upd_sysregs` → stay in PEND; `ovr_cnt` +1, saturating at 255.
  - `vb_edge` → COMMIT.
  - Both in the same cycle → staging takes the new data, `ovr_cnt` +1, go to COMMIT. The new data is what gets committed.
- COMMIT (one cycle):
  - Copy staging to `LocX_reg`, `LocY_reg`, `BotInfo_reg` at the end of the cycle.
  - Registered `upd_ack` is 1 in the following cycle.
  - Next state is PEND if `upd_sysregs` = 1 in this cycle, otherwise IDLE.
  - An update in this cycle is captured after the copy and belongs to the next frame. `ovr_cnt` does not increment.
- `icon_sel` is combinational from `BotInfo_reg[2:0]`.
- Blink:
  - 8-bit `frame_cnt` increments on each `vb_edge`.
  - On reaching `BLINK_FRAMES-1` it wraps to 0 and `blink_ph` toggles.
  - `icon_en` = 1 when `BotInfo_reg[7:4] != 0` (bot moving). Otherwise `icon_en = blink_ph`.
  - `frame_cnt` and `blink_ph` run at all times, independent of the FSM.

## Timing
- Reset values:
  - State IDLE.
  - All staging and committed registers 0, so `icon_sel` = 0.
  - `vblank_d` = 1, which suppresses a false edge out of reset.
  - `ovr_cnt` 0, `frame_cnt` 0, `blink_ph` 1.
  - `upd_ack` 0, `icon_en` 1.
- Reset mid-operation: a pending update is discarded and there is no `upd_ack`.
- Latency:
  - Update to committed output: `vb_edge` cycle + 1 clock (COMMIT) + 1 clock.
  - `upd_ack` rises in the same cycle the new `LocX_reg` becomes visible.
- `vb_edge` is one cycle wide, because `pixel_row` is constant for about 800 pixel clocks. Exactly one commit happens per frame.
- `ovr_cnt` has no clear other than reset.

## Test plan
- Reset, then `upd_sysregs` with X=0x10, Y=0x20, Info=0x13 while `pixel_row` = 100; step `pixel_row` to 480 → `LocX_reg` = 0x10, `LocY_reg` = 0x20, `icon_sel` = 3, and `upd_ack` pulses once, 2 clocks after the edge. Outputs stay unchanged before the edge.
- Three updates X=1, 2, 3 within one frame → commit X=3, `ovr_cnt` = 2.
- `upd_sysregs` (X=5) in the same cycle as `vb_edge` from PEND → committed X=5; from IDLE → no commit until the next frame's edge.
- Update during the COMMIT cycle → the old staged value commits, the new value commits next frame, `ovr_cnt` unchanged, two `upd_ack` pulses in total.
- `BotInfo` movement = 0 with `BLINK_FRAMES` = 2 → `icon_en` toggles every 2 `vb_edge`s; movement = 4 → `icon_en` is steady 1.
- 300 overwrites → `ovr_cnt` holds at 255; assert reset mid-PEND → all outputs return to their reset values and no ack follows.
